// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: in-order fetch queue with fixed latency, flush and backdoor preload.
// Optional IMEM_PERF_EN adds perf_resp/perf_stall counters.
module inst_mem_resp #(
    parameter logic [31:0] RESET       = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned QDEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic                      flush,
    input  logic                      resp_stall,
    output logic                      inst_mem_is_valid,
    output logic [31:0]               inst_mem_read_data,
    output logic [1:0]                inst_mem_offset,
    input  logic                      init_we,
    input  logic [31:0]               init_addr,
    input  logic [31:0]               init_data,
`ifdef IMEM_PERF_EN
    output logic [31:0]               perf_resp,
    output logic [31:0]               perf_stall,
`endif
    output logic [$clog2(QDEPTH):0]   pending
);

    localparam int unsigned PW       = $clog2(QDEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [31:0]   addr_q [QDEPTH];
    logic [31:0]   addr_d [QDEPTH];
    logic [1:0]    cnt_q [QDEPTH];
    logic [1:0]    cnt_d [QDEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q;
    logic [31:0]   data_q;
    logic [1:0]    off_q;
    logic          push, pop, head_rdy;
    logic [31:0]   head_addr, rd_word;

    // Wrapping subtraction done one bit wider so addresses below RESET show up as negative.
    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] diff;
        diff = {1'b0, a} - {1'b0, RESET};
        return !diff[32] && ((diff[31:0] >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - RESET) >> 2);
    endfunction

    // Queue bookkeeping: per-entry countdown, push at tail, pop at head, flush drops all but a same-cycle push.
    always_comb begin
        req_ready = (count_q < CW'(QDEPTH)) && !reset;
        push      = req_valid && req_ready;
        head_rdy  = (count_q != '0) && (cnt_q[head_q] == 2'd0);
        pop       = head_rdy && !resp_stall && !flush;
        head_addr = addr_q[head_q];
        rd_word   = in_range(head_addr) ? mem_q[word_idx(head_addr)] : NOP;
        for (int i = 0; i < int'(QDEPTH); i++) begin
            cnt_d[i]  = (cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : 2'd0;
            addr_d[i] = addr_q[i];
        end
        if (push) begin
            cnt_d[tail_q]  = CNT_INIT;
            addr_d[tail_q] = req_addr;
        end
        tail_d = tail_q + PW'(push);
        if (flush) begin
            head_d  = tail_q;
            count_d = CW'(push);
        end else begin
            head_d  = head_q + PW'(pop);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        cnt_q  <= cnt_d;
    end

    // Backdoor preload; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (init_we && in_range(init_addr)) begin
            mem_q[word_idx(init_addr)] <= init_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            data_q  <= 32'h0;
            off_q   <= 2'b00;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= pop;
            if (pop) begin
                data_q <= rd_word;
                off_q  <= head_addr[1:0];
            end
        end
    end

`ifdef IMEM_PERF_EN
    logic [31:0] perf_resp_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_resp_q  <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (pop)                   perf_resp_q  <= perf_resp_q + 32'd1;
            if (head_rdy && resp_stall) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_resp  = perf_resp_q;
    assign perf_stall = perf_stall_q;
`endif

    assign inst_mem_is_valid  = valid_q;
    assign inst_mem_read_data = data_q;
    assign inst_mem_offset    = off_q;
    assign pending            = count_q;

endmodule
